// File: rtl/tcdm_bank_amo_adapter_if.sv
// Crossbar-port and SRAM-port bundle for tcdm_bank_amo_adapter.
//   req_valid/req_ready/req : TCDM slave request (crossbar -> adapter)
//   rsp_valid/rsp_ready/rsp : TCDM slave response (adapter -> crossbar)
//   mem_*                   : single-port SRAM bank; mem_rdata is valid the
//                             cycle after a read.
// modport slave  : the adapter side.
// modport master : the environment side (crossbar and SRAM together).
interface tcdm_bank_amo_adapter_if #(
  parameter int unsigned NumWords     = 256,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MetaIdWidth  = 6,
  parameter int unsigned CoreIdWidth  = 2,
  parameter int unsigned IniAddrWidth = 2,
  parameter int unsigned TgtAddrWidth = 16
);
  localparam int unsigned AddrWidth = $clog2(NumWords);

  typedef struct packed {
    logic [MetaIdWidth-1:0] meta_id;
    logic [CoreIdWidth-1:0] core_id;
    logic [3:0]             amo;
    logic [DataWidth-1:0]   data;
  } tcdm_payload_t;

  typedef struct packed {
    tcdm_payload_t           wdata;
    logic                    wen;
    logic [DataWidth/8-1:0]  be;
    logic [TgtAddrWidth-1:0] tgt_addr;
    logic [IniAddrWidth-1:0] ini_addr;
  } tcdm_slave_req_t;

  typedef struct packed {
    tcdm_payload_t           rdata;
    logic [IniAddrWidth-1:0] ini_addr;
  } tcdm_slave_resp_t;

  logic                   req_valid;
  logic                   req_ready;
  tcdm_slave_req_t        req;
  logic                   rsp_valid;
  logic                   rsp_ready;
  tcdm_slave_resp_t       rsp;
  logic                   mem_req;
  logic                   mem_we;
  logic [AddrWidth-1:0]   mem_addr;
  logic [DataWidth-1:0]   mem_wdata;
  logic [DataWidth/8-1:0] mem_be;
  logic [DataWidth-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req, rsp_ready, mem_rdata,
    output req_ready, rsp_valid, rsp, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output req_valid, req, rsp_ready, mem_rdata,
    input  req_ready, rsp_valid, rsp, mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/tcdm_bank_amo_adapter.sv
// Bank-side adapter: executes loads, stores, RMW atomics and LR/SC from one
// TCDM crossbar port against one single-port SRAM bank.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus (slave)   : crossbar request/response and SRAM port bundle
// Every accepted request yields exactly one in-order response; meta_id,
// core_id, amo and ini_addr are echoed so routing is transparent.
// Responses are pushed one cycle after acceptance into a fall-through FIFO;
// a credit counter (FIFO entries + in-flight reads) throttles acceptance.
module tcdm_bank_amo_adapter #(
  parameter int unsigned NumWords     = 256,
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MetaIdWidth  = 6,
  parameter int unsigned CoreIdWidth  = 2,
  parameter int unsigned IniAddrWidth = 2,
  parameter int unsigned TgtAddrWidth = 16,
  parameter int unsigned RspDepth     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  tcdm_bank_amo_adapter_if.slave bus
);
  localparam int unsigned AddrWidth = $clog2(NumWords);
  localparam int unsigned BeWidth   = DataWidth / 8;
  localparam int unsigned PtrWidth  = $clog2(RspDepth);
  localparam int unsigned CntWidth  = $clog2(RspDepth + 1);

  localparam logic [3:0] AMO_SWAP = 4'h1;
  localparam logic [3:0] AMO_ADD  = 4'h2;
  localparam logic [3:0] AMO_AND  = 4'h3;
  localparam logic [3:0] AMO_OR   = 4'h4;
  localparam logic [3:0] AMO_XOR  = 4'h5;
  localparam logic [3:0] AMO_MAX  = 4'h6;
  localparam logic [3:0] AMO_MAXU = 4'h7;
  localparam logic [3:0] AMO_MIN  = 4'h8;
  localparam logic [3:0] AMO_MINU = 4'h9;
  localparam logic [3:0] AMO_LR   = 4'hA;
  localparam logic [3:0] AMO_SC   = 4'hB;

  typedef enum logic {IDLE, AMO_WB} state_e;
  // Where the response data comes from when it is pushed at t+1.
  typedef enum logic [1:0] {SRC_RDATA, SRC_ZERO, SRC_ONE} src_e;

  // Same bit layout as the interface response struct.
  typedef struct packed {
    logic [MetaIdWidth-1:0]  meta_id;
    logic [CoreIdWidth-1:0]  core_id;
    logic [3:0]              amo;
    logic [DataWidth-1:0]    data;
    logic [IniAddrWidth-1:0] ini_addr;
  } rsp_t;

  // Request decode
  logic [3:0]           req_amo;
  logic [AddrWidth-1:0] req_addr;
  logic                 is_rmw, is_lr, is_sc, is_plain, sc_ok;
  logic                 accept, pop;
  logic                 unused_tgt_hi;

  state_e               state_q, state_d;
  logic                 rst_done_q;
  logic [CntWidth-1:0]  credits_q;

  // Response stage (one cycle after acceptance)
  logic                    p_vld_q;
  src_e                    p_src_q;
  logic [MetaIdWidth-1:0]  p_meta_q;
  logic [CoreIdWidth-1:0]  p_core_q;
  logic [3:0]              p_amo_q;
  logic [IniAddrWidth-1:0] p_ini_q;

  // Captured atomic operation
  logic [3:0]           amo_op_q;
  logic [DataWidth-1:0] amo_operand_q, amo_old, amo_result;
  logic [AddrWidth-1:0] amo_addr_q;

  // Single-entry LR reservation
  logic                    resv_valid_q;
  logic [CoreIdWidth-1:0]  resv_core_q;
  logic [IniAddrWidth-1:0] resv_ini_q;
  logic [AddrWidth-1:0]    resv_addr_q;

  // Response FIFO
  rsp_t                fifo_q [RspDepth];
  logic [PtrWidth-1:0] wptr_q, rptr_q;
  logic [CntWidth-1:0] count_q;
  logic                fifo_empty, fifo_wr, fifo_rd;
  rsp_t                push_rsp;

  // SRAM drive
  logic                 m_req, m_we;
  logic [AddrWidth-1:0] m_addr;
  logic [DataWidth-1:0] m_wdata;
  logic [BeWidth-1:0]   m_be;

  assign req_amo       = bus.req.wdata.amo;
  assign req_addr      = bus.req.tgt_addr[AddrWidth-1:0];
  assign unused_tgt_hi = ^bus.req.tgt_addr[TgtAddrWidth-1:AddrWidth];
  assign is_rmw        = (req_amo >= AMO_SWAP) && (req_amo <= AMO_MINU);
  assign is_lr         = (req_amo == AMO_LR);
  assign is_sc         = (req_amo == AMO_SC);
  assign is_plain      = !(is_rmw || is_lr || is_sc);
  assign sc_ok         = resv_valid_q && (resv_core_q == bus.req.wdata.core_id) &&
                         (resv_ini_q == bus.req.ini_addr) && (resv_addr_q == req_addr);

  // A pop in this cycle frees a credit, so acceptance can continue at a full
  // credit count. Only registered state and rsp_ready feed this path.
  assign bus.req_ready = rst_done_q && (state_q == IDLE) &&
                         ((credits_q < CntWidth'(RspDepth)) || pop);
  assign accept        = bus.req_valid && bus.req_ready;

  // ---------------------------------------------------------------- FSM / SRAM
  always_comb begin
    state_d = state_q;
    m_req   = 1'b0;
    m_we    = 1'b0;
    m_addr  = '0;
    m_wdata = '0;
    m_be    = '0;
    case (state_q)
      IDLE: begin
        // A failing SC does not touch the bank at all.
        if (accept && !(is_sc && !sc_ok)) begin
          m_req   = 1'b1;
          m_we    = (is_plain && bus.req.wen) || is_sc;
          m_addr  = req_addr;
          m_wdata = bus.req.wdata.data;
          m_be    = is_rmw ? '1 : bus.req.be;
        end
        if (accept && is_rmw) state_d = AMO_WB;
      end
      AMO_WB: begin
        m_req   = 1'b1;
        m_we    = 1'b1;
        m_addr  = amo_addr_q;
        m_wdata = amo_result;
        m_be    = '1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.mem_req   = m_req;
  assign bus.mem_we    = m_we;
  assign bus.mem_addr  = m_addr;
  assign bus.mem_wdata = m_wdata;
  assign bus.mem_be    = m_be;

  // ---------------------------------------------------------------- AMO ALU
  assign amo_old = bus.mem_rdata;

  always_comb begin
    amo_result = amo_operand_q;
    case (amo_op_q)
      AMO_SWAP: amo_result = amo_operand_q;
      AMO_ADD:  amo_result = amo_old + amo_operand_q;
      AMO_AND:  amo_result = amo_old & amo_operand_q;
      AMO_OR:   amo_result = amo_old | amo_operand_q;
      AMO_XOR:  amo_result = amo_old ^ amo_operand_q;
      AMO_MAX:  amo_result = ($signed(amo_old) > $signed(amo_operand_q)) ? amo_old : amo_operand_q;
      AMO_MAXU: amo_result = (amo_old > amo_operand_q) ? amo_old : amo_operand_q;
      AMO_MIN:  amo_result = ($signed(amo_old) < $signed(amo_operand_q)) ? amo_old : amo_operand_q;
      AMO_MINU: amo_result = (amo_old < amo_operand_q) ? amo_old : amo_operand_q;
      default:  amo_result = amo_operand_q;
    endcase
  end

  // ---------------------------------------------------------------- control
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      rst_done_q    <= 1'b0;
      credits_q     <= '0;
      p_vld_q       <= 1'b0;
      p_src_q       <= SRC_ZERO;
      p_meta_q      <= '0;
      p_core_q      <= '0;
      p_amo_q       <= '0;
      p_ini_q       <= '0;
      amo_op_q      <= '0;
      amo_operand_q <= '0;
      amo_addr_q    <= '0;
    end else begin
      state_q    <= state_d;
      rst_done_q <= 1'b1;
      credits_q  <= credits_q + CntWidth'(accept) - CntWidth'(pop);
      p_vld_q    <= accept;
      if (accept) begin
        p_meta_q <= bus.req.wdata.meta_id;
        p_core_q <= bus.req.wdata.core_id;
        p_amo_q  <= req_amo;
        p_ini_q  <= bus.req.ini_addr;
        if (is_sc)                          p_src_q <= sc_ok ? SRC_ZERO : SRC_ONE;
        else if (is_plain && bus.req.wen)   p_src_q <= SRC_ZERO;
        else                                p_src_q <= SRC_RDATA;
      end
      if (accept && is_rmw) begin
        amo_op_q      <= req_amo;
        amo_operand_q <= bus.req.wdata.data;
        amo_addr_q    <= req_addr;
      end
    end
  end

  // ---------------------------------------------------------------- reservation
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      resv_valid_q <= 1'b0;
      resv_core_q  <= '0;
      resv_ini_q   <= '0;
      resv_addr_q  <= '0;
    end else if (accept) begin
      if (is_lr) begin
        resv_valid_q <= 1'b1;
        resv_core_q  <= bus.req.wdata.core_id;
        resv_ini_q   <= bus.req.ini_addr;
        resv_addr_q  <= req_addr;
      end else if (is_sc) begin
        resv_valid_q <= 1'b0;
      end else if (is_plain && bus.req.wen && (req_addr == resv_addr_q)) begin
        resv_valid_q <= 1'b0;
      end
    end else if ((state_q == AMO_WB) && (amo_addr_q == resv_addr_q)) begin
      // Nothing is accepted during write-back, so this cannot race an LR.
      resv_valid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- response FIFO
  always_comb begin
    push_rsp.meta_id  = p_meta_q;
    push_rsp.core_id  = p_core_q;
    push_rsp.amo      = p_amo_q;
    push_rsp.ini_addr = p_ini_q;
    case (p_src_q)
      SRC_RDATA: push_rsp.data = bus.mem_rdata;
      SRC_ONE:   push_rsp.data = DataWidth'(1);
      default:   push_rsp.data = '0;
    endcase
  end

  // Fall-through: with the FIFO empty the pushed entry is presented directly,
  // which is the only way read data (valid at t+1 only) can be shown at t+1.
  assign fifo_empty    = (count_q == '0);
  assign bus.rsp_valid = p_vld_q || !fifo_empty;
  assign bus.rsp       = fifo_empty ? push_rsp : fifo_q[rptr_q];
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign fifo_wr       = p_vld_q && !(fifo_empty && pop);
  assign fifo_rd       = pop && !fifo_empty;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < RspDepth; i++) fifo_q[i] <= '0;
    end else begin
      if (fifo_wr) begin
        fifo_q[wptr_q] <= push_rsp;
        wptr_q <= (wptr_q == PtrWidth'(RspDepth - 1)) ? '0 : wptr_q + 1'b1;
      end
      if (fifo_rd) rptr_q <= (rptr_q == PtrWidth'(RspDepth - 1)) ? '0 : rptr_q + 1'b1;
      count_q <= count_q + CntWidth'(fifo_wr) - CntWidth'(fifo_rd);
    end
  end
endmodule
